// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-back, write-allocate cache controller
// between a CPU load/store port and word-addressed main RAM.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata   CPU request (accepted while cpu_ready=1)
//   cpu_ready         controller idle, can accept a request
//   cpu_done          one-cycle completion pulse
//   cpu_rdata         read data, valid while cpu_done=1
//   hit               high with cpu_done when the first lookup hit
//   mem_req/we/addr/wdata   RAM word request (held until mem_ack)
//   mem_rdata, mem_ack      RAM read data and word-complete strobe
//   hit_count, miss_count   request statistics, only with CACHE_STATS_EN
//
// Optional build macro: CACHE_STATS_EN adds saturating hit/miss counters.
module dm_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 4,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        REFILL
    } state_t;

    state_t state_q, state_d;

    logic [OFF_W-1:0]  cnt_q, cnt_d, cnt_nxt;
    logic              cnt_last;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              miss_q, miss_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;

    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_done_q, cpu_done_d;
    logic              hit_q, hit_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Tag and data storage carry no reset; valid bits guard them.
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];

    logic              arr_we;
    logic [OFF_W-1:0]  arr_off;
    logic [DATA_W-1:0] arr_wdata;
    logic              tag_we;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [TAG_W-1:0]  old_tag;
    logic              cmp_hit;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;

    assign req_off = addr_q[OFF_W-1:0];
    assign req_idx = addr_q[OFF_W +: IDX_W];
    assign req_tag = addr_q[ADDR_W-1 -: TAG_W];
    assign old_tag = tag_q[req_idx];
    assign cmp_hit = valid_q[req_idx] && (old_tag == req_tag);

    // Lookup on the incoming address so that a hit's cpu_done can be
    // registered at acceptance and appear in the very next cycle.
    assign lk_idx = cpu_addr[OFF_W +: IDX_W];
    assign lk_tag = cpu_addr[ADDR_W-1 -: TAG_W];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign cnt_nxt  = cnt_q + OFF_W'(1);
    assign cnt_last = (cnt_q == OFF_W'(WORDS - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        miss_d      = miss_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        cpu_ready_d = cpu_ready_q;
        cpu_done_d  = 1'b0;
        hit_d       = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        arr_we      = 1'b0;
        arr_off     = req_off;
        arr_wdata   = wdata_q;
        tag_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d        = cpu_we;
                    addr_d      = cpu_addr;
                    wdata_d     = cpu_wdata;
                    miss_d      = 1'b0;
                    cpu_ready_d = 1'b0;
                    cpu_done_d  = lk_hit;
                    hit_d       = lk_hit;
                    state_d     = COMPARE;
                end
            end

            COMPARE: begin
                if (cmp_hit) begin
                    if (we_q) begin
                        arr_we           = 1'b1;
                        dirty_d[req_idx] = 1'b1;
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    miss_d    = 1'b1;
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {old_tag, req_idx, {OFF_W{1'b0}}};
                        mem_wdata_d = data_q[req_idx][0];
                        state_d     = WRITEBACK;
                    end else begin
                        // Line contents are about to be overwritten.
                        valid_d[req_idx] = 1'b0;
                        mem_we_d         = 1'b0;
                        mem_addr_d       = {req_tag, req_idx, {OFF_W{1'b0}}};
                        state_d          = REFILL;
                    end
                end
            end

            WRITEBACK: begin
                if (mem_ack) begin
                    if (cnt_last) begin
                        dirty_d[req_idx] = 1'b0;
                        valid_d[req_idx] = 1'b0;
                        cnt_d            = '0;
                        mem_we_d         = 1'b0;
                        mem_addr_d       = {req_tag, req_idx, {OFF_W{1'b0}}};
                        state_d          = REFILL;
                    end else begin
                        cnt_d       = cnt_nxt;
                        mem_addr_d  = {old_tag, req_idx, cnt_nxt};
                        mem_wdata_d = data_q[req_idx][cnt_nxt];
                    end
                end
            end

            REFILL: begin
                if (mem_ack) begin
                    arr_we    = 1'b1;
                    arr_off   = cnt_q;
                    arr_wdata = mem_rdata;
                    if (cnt_last) begin
                        tag_we           = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        cnt_d            = '0;
                        mem_req_d        = 1'b0;
                        mem_we_d         = 1'b0;
                        // The re-compare always hits, so completion is
                        // known now and registered for the next cycle.
                        cpu_done_d       = 1'b1;
                        hit_d            = 1'b0;
                        state_d          = COMPARE;
                    end else begin
                        cnt_d      = cnt_nxt;
                        mem_addr_d = {req_tag, req_idx, cnt_nxt};
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            miss_q      <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
            cpu_ready_q <= 1'b1;
            cpu_done_q  <= 1'b0;
            hit_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            miss_q      <= miss_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_done_q  <= cpu_done_d;
            hit_q       <= hit_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_q[req_idx][arr_off] <= arr_wdata;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_done  = cpu_done_q;
    assign hit       = hit_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Read data is only driven while a completion is being reported.
    assign cpu_rdata = (state_q == COMPARE && cpu_done_q) ?
                       data_q[req_idx][req_off] : '0;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cpu_done_q) begin
            if (hit_q) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed and randomized bench for dm_cache_ctrl
// using a transaction-level cache/RAM model and an on-line monitor.
module tb_dm_cache_ctrl;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        hit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dm_cache_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: cache lines plus backing RAM.
    logic        m_valid [4];
    logic        m_dirty [4];
    logic [31:0] m_tag   [4];
    logic [31:0] m_data  [4][4];
    logic [31:0] ram [int unsigned];

    op_t exp_q[$];
    op_t log_q[$];

    logic        exp_hit;
    logic        exp_we;
    logic [31:0] exp_rdata;
    logic        last_hit;
    logic [31:0] last_rdata;
    int          acc;
    int          memc;
    int          ackn = 0;
    int          max_dly = 0;
    bit          busy = 0;
    bit          done_seen = 0;
    bit          in_reset = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        if (a < 8) return 32'hA0 + (a & 32'd3);
        return 32'hC000_0000 ^ (a * 32'h0001_0003);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Address split: offset = a%4, index = (a/4)%4, tag = a/16.
    task automatic predict(input logic we, input logic [31:0] a,
                           input logic [31:0] wd);
        int idx;
        int off;
        logic [31:0] tg;
        logic [31:0] a2;
        op_t e;
        idx = int'((a >> 2) & 32'd3);
        off = int'(a & 32'd3);
        tg = a >> 4;
        exp_we = we;
        exp_rdata = 32'h0;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            exp_hit = 1'b1;
        end else begin
            exp_hit = 1'b0;
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int w = 0; w < 4; w++) begin
                    a2 = m_tag[idx] * 16 + idx * 4 + w;
                    ram[a2] = m_data[idx][w];
                    e.we = 1'b1;
                    e.addr = a2;
                    e.data = m_data[idx][w];
                    exp_q.push_back(e);
                end
            end
            for (int w = 0; w < 4; w++) begin
                a2 = tg * 16 + idx * 4 + w;
                e.we = 1'b0;
                e.addr = a2;
                e.data = ram_rd(a2);
                exp_q.push_back(e);
                m_data[idx][w] = e.data;
            end
            m_valid[idx] = 1'b1;
            m_tag[idx] = tg;
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            m_data[idx][off] = wd;
            m_dirty[idx] = 1'b1;
        end else begin
            exp_rdata = m_data[idx][off];
        end
    endtask

    // RAM responder: acks after 0..max_dly cycles, checks each word
    // against the model's expected sequence, and sometimes strobes
    // mem_ack while no request is pending.
    initial begin
        int wait_cnt;
        op_t e;
        op_t l;
        wait_cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (reset) begin
                wait_cnt = 0;
            end else if (mem_req) begin
                memc++;
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    l.we = mem_we;
                    l.addr = mem_addr;
                    l.data = mem_wdata;
                    log_q.push_back(l);
                    if (exp_q.size() == 0) begin
                        chk("mem_unexpected_req", 32'h1, 32'h0);
                        mem_rdata = 32'h0;
                    end else begin
                        e = exp_q.pop_front();
                        chk("mem_we", mem_we, e.we);
                        chk("mem_addr", mem_addr, e.addr);
                        if (e.we) chk("mem_wdata", mem_wdata, e.data);
                        mem_rdata = e.data;
                    end
                    mem_ack = 1'b1;
                    ackn++;
                    wait_cnt = (max_dly > 0) ? int'($urandom % (max_dly + 1)) : 0;
                end
            end else begin
                mem_ack = ($urandom % 4) == 0;
                mem_rdata = $urandom;
            end
        end
    end

    // Compare process: every cycle outside reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                if (busy) begin
                    if (cpu_done) begin
                        chk("done_once", done_seen, 1'b0);
                        chk("done_hit", hit, exp_hit);
                        if (!exp_we) chk("done_rdata", cpu_rdata, exp_rdata);
                        chk("done_latency", cyc, exp_hit ? acc : acc + 1 + memc);
                        chk("mem_ops_left", exp_q.size(), 0);
                        last_hit = hit;
                        last_rdata = cpu_rdata;
                        done_seen = 1;
                    end else begin
                        chk("hit_without_done", hit, 1'b0);
                    end
                end else begin
                    chk("idle_ready", cpu_ready, 1'b1);
                    chk("idle_done", cpu_done, 1'b0);
                    chk("idle_mem_req", mem_req, 1'b0);
                end
            end
        end
    end

    task automatic junk();
        cpu_req = 1'($urandom % 2);
        cpu_we = 1'($urandom % 2);
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Called at posedge+2 of a cycle; the request is accepted next edge.
    task automatic start_req(input logic we, input logic [31:0] a,
                             input logic [31:0] wd);
        int n;
        n = 0;
        while (!cpu_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!cpu_ready) begin
            chk("ready_timeout", 32'h0, 32'h1);
            finish_tb();
        end
        predict(we, a, wd);
        memc = 0;
        acc = cyc + 1;
        done_seen = 0;
        busy = 1;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
    endtask

    task automatic finish_req();
        int n;
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #2;
            if (done_seen) break;
            junk();
            n++;
        end
        cpu_req = 1'b0;
        busy = 0;
        if (!done_seen) begin
            chk("done_timeout", 32'h0, 32'h1);
            finish_tb();
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] a,
                          input logic [31:0] wd);
        start_req(we, a, wd);
        finish_req();
    endtask

    initial begin
        logic [31:0] wb_exp [4];
        int base;
        int n;
        wb_exp[0] = 32'hA0;
        wb_exp[1] = 32'hA1;
        wb_exp[2] = 32'hDEAD;
        wb_exp[3] = 32'hA3;
        model_reset();
        reset = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 32'h0;
        cpu_wdata = 32'h0;
        #2;
        chk("rst_cpu_ready", cpu_ready, 1'b1);
        chk("rst_cpu_done", cpu_done, 1'b0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
`ifdef CACHE_STATS_EN
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);
`endif
        idle(3);
        reset = 1'b0;
        in_reset = 0;
        idle(2);

        // Cold read 0x05
        log_q.delete();
        do_req(1'b0, 32'h05, 32'h0);
        chk("s1_hit", last_hit, 1'b0);
        chk("s1_rdata", last_rdata, 32'hA1);
        chk("s1_log_len", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                chk("s1_log_we", log_q[i].we, 1'b0);
                chk("s1_log_addr", log_q[i].addr, 32'h04 + i);
            end
        end
        idle(1);

        // Repeat read 0x05
        log_q.delete();
        do_req(1'b0, 32'h05, 32'h0);
        chk("s2_hit", last_hit, 1'b1);
        chk("s2_rdata", last_rdata, 32'hA1);
        chk("s2_log_len", log_q.size(), 0);
        idle(1);

        // Write hit 0x06, then evicting read 0x45
        log_q.delete();
        do_req(1'b1, 32'h06, 32'hDEAD);
        chk("s3w_hit", last_hit, 1'b1);
        chk("s3w_log_len", log_q.size(), 0);
        idle(1);
        log_q.delete();
        do_req(1'b0, 32'h45, 32'h0);
        chk("s3r_hit", last_hit, 1'b0);
        chk("s3r_log_len", log_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) begin
                if (i < 4) begin
                    chk("s3_wb_we", log_q[i].we, 1'b1);
                    chk("s3_wb_addr", log_q[i].addr, 32'h04 + i);
                    chk("s3_wb_data", log_q[i].data, wb_exp[i]);
                end else begin
                    chk("s3_rf_we", log_q[i].we, 1'b0);
                    chk("s3_rf_addr", log_q[i].addr, 32'h40 + i);
                end
            end
        end
        idle(1);

        // Write miss 0x89 on a clean line, then read it back
        log_q.delete();
        do_req(1'b1, 32'h89, 32'h1234);
        chk("s4w_hit", last_hit, 1'b0);
        chk("s4w_log_len", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                chk("s4_rf_we", log_q[i].we, 1'b0);
                chk("s4_rf_addr", log_q[i].addr, 32'h88 + i);
            end
        end
        idle(1);
        do_req(1'b0, 32'h89, 32'h0);
        chk("s4r_hit", last_hit, 1'b1);
        chk("s4r_rdata", last_rdata, 32'h1234);
        idle(1);

        // Reset after two refill acks
        log_q.delete();
        base = ackn;
        start_req(1'b0, 32'h05, 32'h0);
        n = 0;
        while (ackn < base + 2 && n < 100) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("s5_acks_before_reset", ackn - base, 2);
        @(posedge clk);
        #1;
        in_reset = 1;
        busy = 0;
        cpu_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("s5_mem_req_async", mem_req, 1'b0);
        chk("s5_ready_async", cpu_ready, 1'b1);
        chk("s5_done_async", cpu_done, 1'b0);
        chk("s5_mem_addr_async", mem_addr, 32'h0);
        exp_q.delete();
        model_reset();
        idle(2);
        reset = 1'b0;
        in_reset = 0;
        #3;
        chk("s5_ready_after", cpu_ready, 1'b1);
        idle(1);
        log_q.delete();
        do_req(1'b0, 32'h05, 32'h0);
        chk("s5_hit", last_hit, 1'b0);
        chk("s5_rdata", last_rdata, 32'hA1);
        chk("s5_log_len", log_q.size(), 4);
        idle(1);
        do_req(1'b0, 32'h05, 32'h0);
        chk("s5_rehit", last_hit, 1'b1);
`ifdef CACHE_STATS_EN
        chk("s6_hit_count", hit_count, 32'd1);
        chk("s6_miss_count", miss_count, 32'd1);
`endif
        idle(1);

        // Randomized traffic over 16 tags to force conflicts
        max_dly = 2;
        for (int t = 0; t < 400; t++) begin
            do_req(1'($urandom % 2), 32'($urandom_range(0, 255)), $urandom);
            idle(int'($urandom % 3));
        end
        idle(3);
        chk("final_mem_ops_left", exp_q.size(), 0);
        finish_tb();
    end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Parametrised direct-mapped, write-back, write-allocate cache controller placed between the CPU load/store port and main RAM. It generalises the fixed 4-line x 4-word cache. It adds configurable geometry, valid and dirty bits, multi-word line refill and eviction, and explicit ready/ack handshakes on both the CPU and RAM sides. It replaces single-cycle combinational access with a small FSM.

## Interface
- ADDR_W, 32, word-address width (CPU and RAM)
- DATA_W, 32, word width
- LINES, 4, number of cache lines (power of two, >=2)
- WORDS, 4, words per line (power of two, >=2); OFF_W=log2(WORDS), IDX_W=log2(LINES), TAG_W=ADDR_W-IDX_W-OFF_W
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU request valid
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  word address: offset=[OFF_W-1:0], index=next IDX_W bits, tag=upper TAG_W bits
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  controller can accept a request
- cpu_done  out  1  one-cycle pulse: request complete
- cpu_rdata  out  DATA_W  read data, valid while cpu_done=1
- hit  out  1  high with cpu_done when the first lookup hit
- mem_req  out  1  RAM request valid
- mem_we  out  1  RAM write
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid with mem_ack
- mem_ack  in  1  RAM completes the current word

## Operation
- Storage per line: valid, dirty, tag, WORDS x DATA_W data. Reset clears all valid and dirty bits. The data and tag arrays are not reset.
- FSM states: IDLE, COMPARE, WRITEBACK, REFILL.
- IDLE: cpu_ready=1. On cpu_req=1, latch we/addr/wdata, clear the miss flag, go to COMPARE.
- COMPARE: hit = valid && tag match.
  - Hit on a read: cpu_rdata = line word[offset], pulse cpu_done, go to IDLE.
  - Hit on a write: word[offset] <= wdata, set dirty, pulse cpu_done, go to IDLE.
  - Miss: set the miss flag. Go to WRITEBACK if valid && dirty, else go to REFILL.
- WRITEBACK: word counter 0..WORDS-1. mem_req=1, mem_we=1, mem_addr={old tag, index, cnt}, mem_wdata=word[cnt]. Advance on mem_ack. After the last ack, clear dirty and go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr={new tag, index, cnt}. On mem_ack, word[cnt] <= mem_rdata. After the last ack, set valid and the new tag, clear dirty, go to COMPARE. The second compare always hits; a pending write is then applied over the refilled data.
- hit output = cpu_done && !miss flag.
- cpu_req is ignored while cpu_ready=0.
- mem_ack is ignored while mem_req=0.
- Counter wrap: the word counter resets to 0 on each entry to WRITEBACK or REFILL.

## Timing
- Reset values: cpu_ready=1, cpu_done=0, hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, FSM=IDLE.
- Hit latency: request accepted at edge N, cpu_done/hit/cpu_rdata valid in cycle N+1, cpu_ready=1 again in cycle N+2.
- Miss latency: 1 + (WORDS acks if dirty) + WORDS acks + 1 cycle to cpu_done.
- mem_req stays high across consecutive words. mem_addr, mem_we and mem_wdata change only in the cycle after an ack. mem_req stays high through the cycle where mem_ack=1.
- Reset asserted at any time, including mid-refill: outputs return to their reset values immediately (asynchronously). A line being refilled is left invalid.
- Outputs are registered except cpu_rdata, which is a mux of the array qualified by the COMPARE state.

## Configuration
- CACHE_STATS_EN defined: adds outputs hit_count and miss_count (32 bits each).
  - Reset to 0.
  - One counter increments per completed request, on cpu_done.
  - Counters saturate at 0xFFFFFFFF.
- CACHE_STATS_EN undefined: those ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
All scenarios use default parameters.
- Cold read 0x05. RAM returns 0xA0..0xA3 for addresses 0x04..0x07, with ack 1 cycle after each req.
  - Required: four reads at 0x04..0x07, then cpu_done with cpu_rdata=0xA1, hit=0.
- Repeat read 0x05.
  - Required: cpu_done at N+1, hit=1, cpu_rdata=0xA1, mem_req stays 0.
- Write 0x06 with data 0xDEAD, then read 0x45.
  - Required: the write hits with no RAM traffic.
  - The read evicts: writes to 0x04..0x07 with data 0xA0, 0xA1, 0xDEAD, 0xA3, then reads 0x44..0x47, then hit=0.
- Write miss to 0x89 with 0x1234 on a clean line.
  - Required: refill of 0x88..0x8B, then a read of 0x89 returns 0x1234 with hit=1.
- Assert reset after 2 refill acks.
  - Required: mem_req=0 immediately and cpu_ready=1 after release.
  - Read 0x05 then misses and refills again.
- With CACHE_STATS_EN defined, run scenarios 1–2.
  - Required: hit_count=1, miss_count=1.
